// File: rtl/multi_alarm_ghadi_pkg.sv
// rtl/multi_alarm_ghadi_pkg.sv - shared time constants, slot states and BCD helpers
package multi_alarm_ghadi_pkg;

  localparam int SECS_PER_MIN  = 60;
  localparam int MINS_PER_HOUR = 60;
  localparam int HOURS_PER_DAY = 24;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RINGING = 2'd1,
    SNOOZED = 2'd2
  } slot_state_t;

  function automatic logic [3:0] bcd_tens(input logic [5:0] v);
    return 4'(v / 6'd10);
  endfunction

  function automatic logic [3:0] bcd_ones(input logic [5:0] v);
    return 4'(v % 6'd10);
  endfunction

  function automatic logic [5:0] bcd_to_bin(input logic [3:0] t, input logic [3:0] o);
    return ({2'b00, t} * 6'd10) + {2'b00, o};
  endfunction

  // Hour range is checked on the binary value, so 2/4..2/9 are caught as well as 3/x.
  function automatic logic bcd_time_valid(input logic [1:0] ht, input logic [3:0] ho,
                                          input logic [3:0] mt, input logic [3:0] mo);
    logic [5:0] hour;
    hour = bcd_to_bin({2'b00, ht}, ho);
    return (ho <= 4'd9) && (mt <= 4'd5) && (mo <= 4'd9) &&
           (hour <= 6'(HOURS_PER_DAY - 1));
  endfunction

endpackage

// File: rtl/multi_alarm_ghadi_slot.sv
// rtl/multi_alarm_ghadi_slot.sv - one alarm slot: HH:MM, snooze target, ring counter, FSM
module multi_alarm_ghadi_slot
  import multi_alarm_ghadi_pkg::*;
#(
  parameter int SNOOZE_MIN   = 5,
  parameter int RING_TIMEOUT = 60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       chalu,
  input  logic       band,
  input  logic       snooze,
  input  logic       tick,
  input  logic       block,
  input  logic       load,
  input  logic [4:0] set_hr,
  input  logic [5:0] set_mn,
  input  logic [4:0] cur_hr,
  input  logic [5:0] cur_mn,
  input  logic [4:0] nxt_hr,
  input  logic [5:0] nxt_mn,
  input  logic [5:0] nxt_sec,
  output logic       ringing
);

  slot_state_t state, next_state;
  logic [4:0] al_hr, tg_hr, snz_hr;
  logic [5:0] al_mn, tg_mn, snz_mn;
  logic [7:0] rcnt;
  logic [6:0] sum_mn;
  logic [8:0] rcnt_inc;
  logic       hit_alarm, hit_target, timeout;

  // A time load moves the clock without a tick edge of its own, so it never matches.
  assign hit_alarm  = tick && !block && (nxt_sec == 6'd0) && (nxt_mn == al_mn) && (nxt_hr == al_hr);
  assign hit_target = tick && !block && (nxt_sec == 6'd0) && (nxt_mn == tg_mn) && (nxt_hr == tg_hr);
  assign rcnt_inc   = {1'b0, rcnt} + 9'd1;
  assign timeout    = tick && (rcnt_inc >= 9'(RING_TIMEOUT));

  always_comb begin
    sum_mn = {1'b0, cur_mn} + 7'(SNOOZE_MIN);
    snz_hr = cur_hr;
    snz_mn = 6'(sum_mn);
    if (sum_mn >= 7'(MINS_PER_HOUR)) begin
      snz_mn = 6'(sum_mn - 7'(MINS_PER_HOUR));
      snz_hr = (cur_hr == 5'(HOURS_PER_DAY - 1)) ? 5'd0 : cur_hr + 5'd1;
    end
  end

  always_comb begin
    next_state = state;
    if (!chalu) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE:    if (hit_alarm) next_state = RINGING;
        RINGING: begin
          if (band)         next_state = IDLE;
          else if (snooze)  next_state = SNOOZED;
          else if (timeout) next_state = IDLE;
        end
        SNOOZED: begin
          if (band)            next_state = IDLE;
          else if (hit_target) next_state = RINGING;
        end
        default: next_state = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      al_hr <= '0;
      al_mn <= '0;
      tg_hr <= '0;
      tg_mn <= '0;
      rcnt  <= '0;
    end else begin
      state <= next_state;
      if (load) begin
        al_hr <= set_hr;
        al_mn <= set_mn;
      end
      if (state == RINGING && next_state == SNOOZED) begin
        tg_hr <= snz_hr;
        tg_mn <= snz_mn;
      end
      if (next_state == RINGING && state != RINGING) rcnt <= '0;
      else if (state == RINGING && tick)             rcnt <= rcnt + 8'd1;
    end
  end

  assign ringing = (state == RINGING);

endmodule

// File: rtl/multi_alarm_ghadi.sv
// rtl/multi_alarm_ghadi.sv - 24h BCD clock with tick prescaler, load checking and alarm slots
module multi_alarm_ghadi
  import multi_alarm_ghadi_pkg::*;
#(
  parameter  int CLK_DIV      = 10,
  parameter  int NUM_ALARMS   = 4,
  parameter  int SNOOZE_MIN   = 5,
  parameter  int RING_TIMEOUT = 60,
  localparam int SEL_W        = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1,
  localparam int PS_W         = $clog2(CLK_DIV)
) (
  input  logic                  Ghadi,
  input  logic                  Reset,
  input  logic                  Load_Samay,
  input  logic                  Load_Alarm,
  input  logic [SEL_W-1:0]      Alarm_Sel,
  input  logic [NUM_ALARMS-1:0] Alarm_Chalu,
  input  logic                  Alarm_Band,
  input  logic                  Snooze,
  input  logic [1:0]            Hr_T_IN,
  input  logic [3:0]            Hr_O_IN,
  input  logic [3:0]            Mn_T_IN,
  input  logic [3:0]            Mn_O_IN,
  output logic [1:0]            Hr_T_OUT,
  output logic [3:0]            Hr_O_OUT,
  output logic [3:0]            Mn_T_OUT,
  output logic [3:0]            Mn_O_OUT,
  output logic [3:0]            Sc_T_OUT,
  output logic [3:0]            Sc_O_OUT,
  output logic                  Tick_1s,
  output logic                  Alarm,
  output logic [NUM_ALARMS-1:0] Alarm_Active,
  output logic                  Load_Err
);

  logic [PS_W-1:0] ps;
  logic [5:0] sec, mn, inc_sec, inc_mn, in_hr, in_mn;
  logic [4:0] hr, inc_hr;
  logic       in_ok, samay_ld, alarm_ld;

  assign Tick_1s  = (ps == PS_W'(CLK_DIV - 1));
  assign in_hr    = bcd_to_bin({2'b00, Hr_T_IN}, Hr_O_IN);
  assign in_mn    = bcd_to_bin(Mn_T_IN, Mn_O_IN);
  assign in_ok    = bcd_time_valid(Hr_T_IN, Hr_O_IN, Mn_T_IN, Mn_O_IN);
  assign samay_ld = Load_Samay && in_ok;
  assign alarm_ld = Load_Alarm && in_ok;

  always_comb begin
    inc_sec = sec + 6'd1;
    inc_mn  = mn;
    inc_hr  = hr;
    if (sec == 6'(SECS_PER_MIN - 1)) begin
      inc_sec = 6'd0;
      if (mn == 6'(MINS_PER_HOUR - 1)) begin
        inc_mn = 6'd0;
        inc_hr = (hr == 5'(HOURS_PER_DAY - 1)) ? 5'd0 : hr + 5'd1;
      end else begin
        inc_mn = mn + 6'd1;
      end
    end
  end

  always_ff @(posedge Ghadi or posedge Reset) begin
    if (Reset) begin
      ps       <= '0;
      sec      <= '0;
      mn       <= '0;
      hr       <= '0;
      Load_Err <= 1'b0;
    end else begin
      Load_Err <= (Load_Samay || Load_Alarm) && !in_ok;
      if (samay_ld) begin
        ps  <= '0;
        sec <= '0;
        mn  <= in_mn;
        hr  <= 5'(in_hr);
      end else if (Tick_1s) begin
        ps  <= '0;
        sec <= inc_sec;
        mn  <= inc_mn;
        hr  <= inc_hr;
      end else begin
        ps <= ps + PS_W'(1);
      end
    end
  end

  assign Hr_T_OUT = 2'(bcd_tens({1'b0, hr}));
  assign Hr_O_OUT = bcd_ones({1'b0, hr});
  assign Mn_T_OUT = bcd_tens(mn);
  assign Mn_O_OUT = bcd_ones(mn);
  assign Sc_T_OUT = bcd_tens(sec);
  assign Sc_O_OUT = bcd_ones(sec);

  for (genvar i = 0; i < NUM_ALARMS; i++) begin : g_slot
    multi_alarm_ghadi_slot #(
      .SNOOZE_MIN  (SNOOZE_MIN),
      .RING_TIMEOUT(RING_TIMEOUT)
    ) u_slot (
      .clk    (Ghadi),
      .rst    (Reset),
      .chalu  (Alarm_Chalu[i]),
      .band   (Alarm_Band),
      .snooze (Snooze),
      .tick   (Tick_1s),
      .block  (samay_ld),
      .load   (alarm_ld && (Alarm_Sel == SEL_W'(i))),
      .set_hr (5'(in_hr)),
      .set_mn (in_mn),
      .cur_hr (hr),
      .cur_mn (mn),
      .nxt_hr (inc_hr),
      .nxt_mn (inc_mn),
      .nxt_sec(inc_sec),
      .ringing(Alarm_Active[i])
    );
  end

  assign Alarm = |Alarm_Active;

endmodule
